id_ex_skid_stage: RTL

Parametrised ID/EX pipeline stage register with valid/ready handshaking, a one-entry skid buffer, synchronous flush (bubble insertion) and a saturating back-pressure counter. It sits between decode and execute in the 5-stage RISC-V core. It carries two register-file operands, destination register, ALU control and NUM_CH generic 32-bit side channels. Unlike a plain stage register, it absorbs back-pressure from EX at full throughput and clears every output, including ALU control, on reset, flush and drain.

---
 rtl/id_ex_skid_stage_if.sv | 26 ++
 rtl/id_ex_skid_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/id_ex_skid_stage_if.sv
// ID/EX handshake bundle: valid/ready plus decoded payload.
// master drives valid and payload, slave drives ready.
interface id_ex_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4,
  parameter int NUM_CH = 6
) ();
  logic                     valid;
  logic                     ready;
  logic [DATA_W-1:0]        data1;
  logic [DATA_W-1:0]        data2;
  logic [RD_W-1:0]          rd;
  logic [CTRL_W-1:0]        ctrl;
  logic [NUM_CH*DATA_W-1:0] ch;

  modport master (
    output valid, data1, data2, rd, ctrl, ch,
    input  ready
  );

  modport slave (
    input  valid, data1, data2, rd, ctrl, ch,
    output ready
  );
endinterface

// File: rtl/id_ex_skid_stage.sv
// ID/EX stage register with one-entry skid buffer,
// flush-to-bubble and saturating back-pressure counter.
module id_ex_skid_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4,
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  id_ex_skid_stage_if.slave  up,
  id_ex_skid_stage_if.master dn,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]        d1;
    logic [DATA_W-1:0]        d2;
    logic [RD_W-1:0]          rd;
    logic [CTRL_W-1:0]        ctrl;
    logic [NUM_CH*DATA_W-1:0] ch;
  } id_ex_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t st_q, st_n;
  id_ex_t m_q, m_n;
  id_ex_t s_q, s_n;
  id_ex_t in_beat;
  logic   rdy_q;
  logic   accept;
  logic   rel;

  assign in_beat = {up.data1, up.data2, up.rd,
                    up.ctrl, up.ch};

  assign up.ready  = rdy_q;
  assign dn.valid  = (st_q != EMPTY);
  assign dn.data1  = m_q.d1;
  assign dn.data2  = m_q.d2;
  assign dn.rd     = m_q.rd;
  assign dn.ctrl   = m_q.ctrl;
  assign dn.ch     = m_q.ch;

  assign accept = up.valid & rdy_q;
  assign rel    = dn.valid & dn.ready;

  // Next-state and entry movement; flush squashes everything.
  always_comb begin
    st_n = st_q;
    m_n  = m_q;
    s_n  = s_q;
    case (st_q)
      EMPTY: begin
        if (accept) begin
          st_n = ONE;
          m_n  = in_beat;
        end
      end
      ONE: begin
        unique case (1'b1)
          accept & rel: m_n = in_beat;
          accept & !rel: begin
            st_n = TWO;
            s_n  = in_beat;
          end
          !accept & rel: begin
            st_n = EMPTY;
            m_n  = '0;
          end
          default: ;
        endcase
      end
      TWO: begin
        if (rel) begin
          st_n = ONE;
          m_n  = s_q;
          s_n  = '0;
        end
      end
      default: begin
        st_n = EMPTY;
        m_n  = '0;
        s_n  = '0;
      end
    endcase
    if (flush) begin
      st_n = EMPTY;
      m_n  = '0;
      s_n  = '0;
    end
  end

  // State, entries and registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= EMPTY;
      m_q   <= '0;
      s_q   <= '0;
      rdy_q <= 1'b1;
    end else begin
      st_q  <= st_n;
      m_q   <= m_n;
      s_q   <= s_n;
      rdy_q <= (st_n != TWO);
    end
  end

  // Count stalled cycles, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (dn.valid && !dn.ready &&
                 stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
